// File: rtl/uart_tx_fifo_drain_pkg.sv
// ============================================================================
// Module  : uart_tx_fifo_drain_pkg
// Brief   : Shared state encoding, default baud divisor and line-level helper.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package uart_tx_fifo_drain_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LOAD  = 3'd1,
        ST_START = 3'd2,
        ST_DATA  = 3'd3,
        ST_STOP  = 3'd4
    } tx_state_e;

    localparam int          BAUD_W                  = 24;
    localparam logic [23:0] DEFAULT_CLOCKS_PER_BAUD = 24'd104;

    // Serial line level for a given frame state; idle, load and stop are all mark.
    function automatic logic line_level(input tx_state_e st, input logic data_lsb);
        logic lvl;
        lvl = 1'b1;
        case (st)
            ST_START: lvl = 1'b0;
            ST_DATA:  lvl = data_lsb;
            default:  lvl = 1'b1;
        endcase
        return lvl;
    endfunction

endpackage

`default_nettype wire

// File: rtl/uart_tx_fifo_drain_baud_timer.sv
// ============================================================================
// Module  : uart_tx_fifo_drain_baud_timer
// Brief   : Loadable down-counter that holds at zero and flags tick while zero.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module uart_tx_fifo_drain_baud_timer
    import uart_tx_fifo_drain_pkg::*;
#(
    parameter int W = BAUD_W
) (
    input  logic         i_clk,
    input  logic         i_rst_n,
    input  logic         i_load,
    input  logic [W-1:0] i_load_val,
    output logic         o_tick
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (i_load) begin
            cnt_d = i_load_val;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - W'(1);
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign o_tick = (cnt_q == '0);

endmodule

`default_nettype wire

// File: rtl/uart_tx_fifo_drain.sv
// ============================================================================
// Module  : uart_tx_fifo_drain
// Brief   : Pops bytes from a show-ahead FIFO and sends each as an 8N1 frame.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module uart_tx_fifo_drain
    import uart_tx_fifo_drain_pkg::*;
#(
    parameter logic [23:0] CLOCKS_PER_BAUD = DEFAULT_CLOCKS_PER_BAUD,
    parameter int          CNT_W           = 16
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_empty_n,
    input  logic [7:0]       i_data,
    input  logic             i_hold,
    output logic             o_rd,
    output logic             o_uart_tx,
    output logic             o_busy,
    output logic [CNT_W-1:0] o_tx_count
);

    tx_state_e        state_q, state_d;
    logic [7:0]       shreg_q, shreg_d;
    logic [2:0]       bit_idx_q, bit_idx_d;
    logic [CNT_W-1:0] tx_count_q, tx_count_d;
    logic             tx_q, tx_d;
    logic             baud_load;
    logic             baud_tick;

    uart_tx_fifo_drain_baud_timer #(
        .W (BAUD_W)
    ) u_baud_timer (
        .i_clk      (i_clk),
        .i_rst_n    (i_rst_n),
        .i_load     (baud_load),
        .i_load_val (CLOCKS_PER_BAUD - 24'd1),
        .o_tick     (baud_tick)
    );

    always_comb begin
        state_d    = state_q;
        shreg_d    = shreg_q;
        bit_idx_d  = bit_idx_q;
        tx_count_d = tx_count_q;
        baud_load  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (i_empty_n && !i_hold) begin
                    state_d = ST_LOAD;
                end
            end
            ST_LOAD: begin
                shreg_d   = i_data;
                baud_load = 1'b1;
                state_d   = ST_START;
            end
            ST_START: begin
                if (baud_tick) begin
                    baud_load = 1'b1;
                    bit_idx_d = 3'd0;
                    state_d   = ST_DATA;
                end
            end
            ST_DATA: begin
                if (baud_tick) begin
                    baud_load = 1'b1;
                    shreg_d   = {1'b0, shreg_q[7:1]};
                    if (bit_idx_q == 3'd7) begin
                        state_d = ST_STOP;
                    end else begin
                        bit_idx_d = bit_idx_q + 3'd1;
                    end
                end
            end
            ST_STOP: begin
                // Stop bit runs full length; the next pop is decided only here.
                if (baud_tick) begin
                    tx_count_d = tx_count_q + CNT_W'(1);
                    state_d    = (i_empty_n && !i_hold) ? ST_LOAD : ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        // Line level follows the next state so the registered output is aligned to it.
        tx_d = line_level(state_d, shreg_d[0]);
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state_q    <= ST_IDLE;
            shreg_q    <= 8'h00;
            bit_idx_q  <= 3'd0;
            tx_count_q <= '0;
            tx_q       <= 1'b1;
        end else begin
            state_q    <= state_d;
            shreg_q    <= shreg_d;
            bit_idx_q  <= bit_idx_d;
            tx_count_q <= tx_count_d;
            tx_q       <= tx_d;
        end
    end

    assign o_rd       = (state_q == ST_LOAD);
    assign o_uart_tx  = tx_q;
    assign o_busy     = (state_q != ST_IDLE);
    assign o_tx_count = tx_count_q;

endmodule

`default_nettype wire
